// File: rtl/wb_store_issuer_pkg.sv
// wb_store_issuer_pkg
//   Shared definitions for the writeback store issuer: store size encodings,
//   entry field widths and the 16-byte line compare helper used by the probe.
//   Ports: none (package).
//   Configuration: WB_STORE_PROBE_EN selects the address-compare probe
//   (line_match is only referenced when that macro is defined).
package wb_store_issuer_pkg;

  typedef enum logic [1:0] {
    SZ_1B = 2'b00,
    SZ_2B = 2'b01,
    SZ_4B = 2'b10,
    SZ_8B = 2'b11
  } size_e;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 64;
  localparam int SIZE_W     = 2;
  localparam int LINE_OFS_W = 4;

  // Two addresses fall in the same 16-byte line.
  function automatic logic line_match(input logic [ADDR_W-1:0] a,
                                      input logic [ADDR_W-1:0] b);
    return a[ADDR_W-1:LINE_OFS_W] == b[ADDR_W-1:LINE_OFS_W];
  endfunction

endpackage

// File: rtl/wb_store_issuer_entry_ram.sv
// wb_store_issuer_entry_ram
//   DEPTH x {addr,data,size,ptcid} register file for the store queue.
//   One write port (tail slot), one combinational read port (head slot) and,
//   when WB_STORE_PROBE_EN is defined, a parallel read-out of every slot's
//   address for the probe compare. All slots clear to zero on clr.
//   Ports:
//     clk, clr                 clock, async active-high reset
//     wr_en/wr_ptr/wr_*        write port
//     rd_ptr/rd_*              combinational read port
//     all_addr                 every slot's address (WB_STORE_PROBE_EN only)
module wb_store_issuer_entry_ram
  import wb_store_issuer_pkg::*;
#(
  parameter  int DEPTH   = 4,
  parameter  int PTCID_W = 1,
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               wr_en,
  input  logic [PTR_W-1:0]   wr_ptr,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic [SIZE_W-1:0]  wr_size,
  input  logic [PTCID_W-1:0] wr_ptcid,
  input  logic [PTR_W-1:0]   rd_ptr,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0]  rd_data,
  output logic [SIZE_W-1:0]  rd_size,
  output logic [PTCID_W-1:0] rd_ptcid
`ifdef WB_STORE_PROBE_EN
  ,
  output logic [ADDR_W-1:0]  all_addr [DEPTH]
`endif
);

  logic [ADDR_W-1:0]  addr_mem  [DEPTH];
  logic [DATA_W-1:0]  data_mem  [DEPTH];
  logic [SIZE_W-1:0]  size_mem  [DEPTH];
  logic [PTCID_W-1:0] ptcid_mem [DEPTH];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i]  <= '0;
        data_mem[i]  <= '0;
        size_mem[i]  <= '0;
        ptcid_mem[i] <= '0;
      end
    end else if (wr_en) begin
      addr_mem[wr_ptr]  <= wr_addr;
      data_mem[wr_ptr]  <= wr_data;
      size_mem[wr_ptr]  <= wr_size;
      ptcid_mem[wr_ptr] <= wr_ptcid;
    end
  end

  assign rd_addr  = addr_mem[rd_ptr];
  assign rd_data  = data_mem[rd_ptr];
  assign rd_size  = size_mem[rd_ptr];
  assign rd_ptcid = ptcid_mem[rd_ptr];

`ifdef WB_STORE_PROBE_EN
  assign all_addr = addr_mem;
`endif

endmodule

// File: rtl/wb_store_issuer.sv
// wb_store_issuer
//   Store-side sender for the d$ writeback address queue. Committed stores
//   from WB are buffered in a DEPTH-entry FIFO and offered in commit order on
//   the wb_* interface, honouring wbaq_isfull backpressure.
//   Ports:
//     clk, clr                          clock, async active-high reset
//     st_valid/st_addr/st_data/
//     st_size/st_ptcid                  store from WB
//     st_stall                          FIFO full, WB must hold
//     wb_valid/wb_memaddr/wb_memdata/
//     wb_size/wb_ptcid                  head entry offered to d$
//     wbaq_isfull                       d$ cannot accept this cycle
//     probe_valid/probe_addr/probe_hit  M-stage read alias probe
//     sq_empty                          nothing pending
//   Configuration: define WB_STORE_PROBE_EN for a per-entry 16-byte line
//   compare; otherwise any pending store makes a valid probe hit.
module wb_store_issuer
  import wb_store_issuer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int PTCID_W = 1
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               st_valid,
  input  logic [ADDR_W-1:0]  st_addr,
  input  logic [DATA_W-1:0]  st_data,
  input  logic [SIZE_W-1:0]  st_size,
  input  logic [PTCID_W-1:0] st_ptcid,
  output logic               st_stall,
  output logic               wb_valid,
  output logic [ADDR_W-1:0]  wb_memaddr,
  output logic [DATA_W-1:0]  wb_memdata,
  output logic [SIZE_W-1:0]  wb_size,
  output logic [PTCID_W-1:0] wb_ptcid,
  input  logic               wbaq_isfull,
  input  logic               probe_valid,
  input  logic [ADDR_W-1:0]  probe_addr,
  output logic               probe_hit,
  output logic               sq_empty
);

  localparam int             PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count;
  logic             push, pop;

  // Full is judged on count alone: a pop on the same edge does not free a
  // slot for the incoming store.
  assign st_stall = (count == CNT_FULL);
  assign sq_empty = (count == '0);
  assign wb_valid = ~sq_empty & ~wbaq_isfull;
  assign push     = st_valid & ~st_stall;
  assign pop      = wb_valid;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

`ifdef WB_STORE_PROBE_EN
  logic [ADDR_W-1:0] all_addr [DEPTH];
`endif

  wb_store_issuer_entry_ram #(
    .DEPTH   (DEPTH),
    .PTCID_W (PTCID_W)
  ) u_ram (
    .clk      (clk),
    .clr      (clr),
    .wr_en    (push),
    .wr_ptr   (tail),
    .wr_addr  (st_addr),
    .wr_data  (st_data),
    .wr_size  (st_size),
    .wr_ptcid (st_ptcid),
    .rd_ptr   (head),
    .rd_addr  (wb_memaddr),
    .rd_data  (wb_memdata),
    .rd_size  (wb_size),
    .rd_ptcid (wb_ptcid)
`ifdef WB_STORE_PROBE_EN
    ,
    .all_addr (all_addr)
`endif
  );

`ifdef WB_STORE_PROBE_EN
  // A slot is live when its distance from head is below count; the entry
  // leaving this cycle is still live, so it still blocks the read.
  always_comb begin
    probe_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (({1'b0, PTR_W'(PTR_W'(i) - head)} < count) &&
          line_match(all_addr[i], probe_addr))
        probe_hit = 1'b1;
    end
    probe_hit = probe_hit & probe_valid;
  end
`else
  logic probe_addr_unused;
  assign probe_addr_unused = ^probe_addr;
  assign probe_hit         = probe_valid & ~sq_empty;
`endif

endmodule

// File: tb/tb_wb_store_issuer.sv
// tb_wb_store_issuer
//   Directed and random stimulus against a queue-based model of the store
//   FIFO. Probe expectations follow WB_STORE_PROBE_EN when it is defined.
module tb_wb_store_issuer;

  localparam int DEPTH   = 4;
  localparam int PTCID_W = 1;

  logic               clk = 1'b0;
  logic               clr;
  logic               st_valid;
  logic [31:0]        st_addr;
  logic [63:0]        st_data;
  logic [1:0]         st_size;
  logic [PTCID_W-1:0] st_ptcid;
  logic               st_stall;
  logic               wb_valid;
  logic [31:0]        wb_memaddr;
  logic [63:0]        wb_memdata;
  logic [1:0]         wb_size;
  logic [PTCID_W-1:0] wb_ptcid;
  logic               wbaq_isfull;
  logic               probe_valid;
  logic [31:0]        probe_addr;
  logic               probe_hit;
  logic               sq_empty;

  always #5 clk = ~clk;

  wb_store_issuer #(.DEPTH(DEPTH), .PTCID_W(PTCID_W)) dut (
    .clk         (clk),
    .clr         (clr),
    .st_valid    (st_valid),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_size     (st_size),
    .st_ptcid    (st_ptcid),
    .st_stall    (st_stall),
    .wb_valid    (wb_valid),
    .wb_memaddr  (wb_memaddr),
    .wb_memdata  (wb_memdata),
    .wb_size     (wb_size),
    .wb_ptcid    (wb_ptcid),
    .wbaq_isfull (wbaq_isfull),
    .probe_valid (probe_valid),
    .probe_addr  (probe_addr),
    .probe_hit   (probe_hit),
    .sq_empty    (sq_empty)
  );

  typedef struct {
    logic [31:0]        a;
    logic [63:0]        d;
    logic [1:0]         s;
    logic [PTCID_W-1:0] p;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_probe(input logic pv, input logic [31:0] pa);
    logic hit = 1'b0;
`ifdef WB_STORE_PROBE_EN
    foreach (q[i]) if ((q[i].a >> 4) == (pa >> 4)) hit = 1'b1;
`else
    hit = (q.size() != 0);
`endif
    return pv & hit;
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, then let
  // the edge happen and advance the model the same way.
  task automatic cycle(input logic v, input logic [31:0] a, input logic [63:0] d,
                       input logic [1:0] sz, input logic pt, input logic full,
                       input logic pv, input logic [31:0] pa);
    ent_t e;
    logic pop_now, push_now;
    st_valid = v; st_addr = a; st_data = d; st_size = sz; st_ptcid = pt;
    wbaq_isfull = full; probe_valid = pv; probe_addr = pa;
    #1;
    check("st_stall", st_stall, q.size() == DEPTH);
    check("sq_empty", sq_empty, q.size() == 0);
    check("wb_valid", wb_valid, q.size() != 0 && !full);
    if (q.size() != 0) begin
      check("wb_memaddr", wb_memaddr, q[0].a);
      check("wb_memdata", wb_memdata, q[0].d);
      check("wb_size",    wb_size,    q[0].s);
      check("wb_ptcid",   wb_ptcid,   q[0].p);
    end
    check("probe_hit", probe_hit, exp_probe(pv, pa));
    pop_now  = (q.size() != 0) && !full;
    push_now = v && (q.size() != DEPTH);
    if (pop_now) void'(q.pop_front());
    if (push_now) begin
      e.a = a; e.d = d; e.s = sz; e.p = pt;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_wb_valid"}, wb_valid, 1'b0);
    check({tag, "_sq_empty"}, sq_empty, 1'b1);
    check({tag, "_st_stall"}, st_stall, 1'b0);
    check({tag, "_probe_hit"}, probe_hit, 1'b0);
    check({tag, "_wb_memaddr"}, wb_memaddr, 32'h0);
    check({tag, "_wb_memdata"}, wb_memdata, 64'h0);
    check({tag, "_wb_size"}, wb_size, 2'b00);
    check({tag, "_wb_ptcid"}, wb_ptcid, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    clr = 1'b1; st_valid = 0; st_addr = 0; st_data = 0; st_size = 0; st_ptcid = 0;
    wbaq_isfull = 0; probe_valid = 1; probe_addr = 32'h1000;
    @(posedge clk); #1;
    check_cleared("reset");
    clr = 1'b0;
    probe_valid = 0;

    // single store, one-cycle latency, then drained
    cycle(1, 32'h1000, 64'h11, 2'b00, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);

    // fill under backpressure, fifth store ignored, then drain in order
    for (int i = 0; i < 5; i++)
      cycle(1, 32'h100 + 32'(i) * 8, 64'hA0 + 64'(i), 2'(i), 1'(i), 1, 0, 0);
    for (int i = 0; i < 5; i++)
      cycle(0, 0, 0, 0, 0, 0, 0, 0);

    // steady push+pop at count 2 across pointer wrap
    cycle(1, 32'h300, 64'h300, 2'b10, 0, 1, 0, 0);
    cycle(1, 32'h304, 64'h304, 2'b10, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++)
      cycle(1, 32'h308 + 32'(i) * 4, 64'h308 + 64'(i), 2'b01, 1'(i), 0, 0, 0);
    for (int i = 0; i < 3; i++)
      cycle(0, 0, 0, 0, 0, 0, 0, 0);

    // async clear with stores pending
    for (int i = 0; i < 4; i++)
      cycle(1, 32'h500 + 32'(i), 64'h500 + 64'(i), 2'b11, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    st_valid = 0; wbaq_isfull = 0; probe_valid = 1; probe_addr = 32'h500;
    #2 clr = 1'b1;
    #1 check_cleared("clr_mid");
    clr = 1'b0;
    q.delete();
    @(posedge clk); #1;
    cycle(1, 32'h600, 64'h600, 2'b00, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);

    // probe against a pending store at 0x2008
    cycle(1, 32'h2008, 64'h77, 2'b10, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 1, 32'h200C);
    cycle(0, 0, 0, 0, 0, 1, 1, 32'h2010);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'h2000);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'h2008);

    // full 64-bit data
    cycle(1, 32'h3000, 64'hDEADBEEF_CAFEF00D, 2'b11, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);

    // random traffic, addresses clustered so probes both hit and miss
    for (int i = 0; i < 400; i++) begin
      ra = 32'h4000 + 32'($urandom_range(0, 7)) * 8;
      cycle(1'($urandom_range(0, 1)), ra, {$urandom, $urandom}, 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 1)), 32'h4000 + 32'($urandom_range(0, 63)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
